// File: rtl/mem_pkg.sv
// Shared types and helpers for the memory requester: burst size codes,
// requester FSM states and the burst-length decode.
package mem_pkg;

    localparam int unsigned DATA_W             = 32;
    localparam int unsigned ADDR_W             = 32;
    localparam int unsigned WORD_CNT_W         = 4;
    localparam int unsigned DRAIN_CNT_W        = 5;
    localparam int unsigned DRAIN_CYCLES_DEF   = 18;

    // Burst size code as understood by the memory.
    typedef enum logic [1:0] {
        SIZE_1W  = 2'd0,
        SIZE_4W  = 2'd1,
        SIZE_8W  = 2'd2,
        SIZE_16W = 2'd3
    } size_e;

    // Requester FSM states.
    typedef enum logic [2:0] {
        ST_DRAIN = 3'd0,
        ST_IDLE  = 3'd1,
        ST_ISSUE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_DATA  = 3'd4,
        ST_WRITE = 3'd5
    } state_e;

    // Number of words in a burst for a given size code (1, 4, 8 or 16).
    function automatic logic [4:0] burst_len(input size_e size);
        logic [4:0] len;
        case (size)
            SIZE_1W:  len = 5'd1;
            SIZE_4W:  len = 5'd4;
            SIZE_8W:  len = 5'd8;
            SIZE_16W: len = 5'd16;
            default:  len = 5'd1;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/mem_requester.sv
// Initiator-side controller for the single-port burst word memory.
// Takes one client request at a time, pulses the memory enable for exactly
// one cycle, then registers the returned burst words into a valid-tagged
// response stream. Writes are single-word and produce no response.
module mem_requester
    import mem_pkg::*;
#(
    parameter int unsigned DRAIN_CYCLES = DRAIN_CYCLES_DEF
) (
    input  logic                  clk_i,
    input  logic                  reset_i,

    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_write_i,
    input  logic [1:0]            req_size_i,
    input  logic [ADDR_W-1:0]     req_addr_i,
    input  logic [DATA_W-1:0]     req_wdata_i,

    output logic                  rsp_valid_o,
    output logic [DATA_W-1:0]     rsp_data_o,
    output logic [WORD_CNT_W-1:0] rsp_index_o,
    output logic                  rsp_last_o,

    output logic                  mem_enable_o,
    output logic                  mem_rd_wr_o,
    output logic [1:0]            mem_access_size_o,
    output logic [ADDR_W-1:0]     mem_addr_o,
    output logic [DATA_W-1:0]     mem_data_in_o,
    input  logic [DATA_W-1:0]     mem_data_out_i
);

    localparam logic [DRAIN_CNT_W-1:0] DRAIN_INIT = DRAIN_CNT_W'(DRAIN_CYCLES);

    // FSM and counters
    state_e                  state_q,     state_d;
    logic [DRAIN_CNT_W-1:0]  drain_cnt_q, drain_cnt_d;
    logic [WORD_CNT_W-1:0]   word_cnt_q,  word_cnt_d;
    logic [WORD_CNT_W-1:0]   last_idx_q,  last_idx_d;

    // Registered memory-side outputs (also hold the latched request)
    logic                    mem_enable_q, mem_enable_d;
    logic                    mem_rd_wr_q,  mem_rd_wr_d;
    size_e                   mem_size_q,   mem_size_d;
    logic [ADDR_W-1:0]       mem_addr_q,   mem_addr_d;
    logic [DATA_W-1:0]       mem_wdata_q,  mem_wdata_d;

    // Registered client-side response outputs
    logic                    rsp_valid_q,  rsp_valid_d;
    logic [DATA_W-1:0]       rsp_data_q,   rsp_data_d;
    logic [WORD_CNT_W-1:0]   rsp_index_q,  rsp_index_d;
    logic                    rsp_last_q,   rsp_last_d;

    // Decode of the incoming request
    size_e                   req_size;
    logic [4:0]              req_len;
    logic [WORD_CNT_W-1:0]   req_last_idx;
    logic [ADDR_W-1:0]       req_word_addr;
    logic                    unused_addr_lsb;

    assign req_size        = size_e'(req_size_i);
    assign req_len         = burst_len(req_size);
    assign req_last_idx    = WORD_CNT_W'(req_len - 5'd1);
    assign req_word_addr   = {req_addr_i[ADDR_W-1:2], 2'b00};
    assign unused_addr_lsb = ^req_addr_i[1:0];

    // Next-state and next-output logic of the requester FSM.
    always_comb begin
        state_d      = state_q;
        drain_cnt_d  = drain_cnt_q;
        word_cnt_d   = word_cnt_q;
        last_idx_d   = last_idx_q;
        mem_enable_d = 1'b0;
        mem_rd_wr_d  = mem_rd_wr_q;
        mem_size_d   = mem_size_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        rsp_valid_d  = 1'b0;
        rsp_last_d   = 1'b0;
        rsp_data_d   = rsp_data_q;
        rsp_index_d  = rsp_index_q;

        case (state_q)
            ST_DRAIN: begin
                // Memory is kept idle; whatever it still streams is ignored.
                mem_rd_wr_d = 1'b1;
                if (drain_cnt_q > 5'd1) begin
                    drain_cnt_d = drain_cnt_q - 5'd1;
                end else begin
                    drain_cnt_d = 5'd0;
                    state_d     = ST_IDLE;
                end
            end

            ST_IDLE: begin
                if (req_valid_i) begin
                    mem_enable_d = 1'b1;
                    mem_addr_d   = req_word_addr;
                    word_cnt_d   = 4'd0;
                    if (req_write_i) begin
                        mem_rd_wr_d = 1'b0;
                        mem_size_d  = SIZE_1W;
                        mem_wdata_d = req_wdata_i;
                        state_d     = ST_WRITE;
                    end else begin
                        mem_rd_wr_d = 1'b1;
                        mem_size_d  = req_size;
                        last_idx_d  = req_last_idx;
                        state_d     = ST_ISSUE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_ISSUE: begin
                // Enable was high for this cycle only; the default drops it.
                state_d = ST_WAIT;
            end

            ST_WAIT: begin
                // Memory is loading its first word.
                state_d = ST_DATA;
            end

            ST_DATA: begin
                rsp_valid_d = 1'b1;
                rsp_data_d  = mem_data_out_i;
                rsp_index_d = word_cnt_q;
                if (word_cnt_q == last_idx_q) begin
                    rsp_last_d = 1'b1;
                    word_cnt_d = 4'd0;
                    state_d    = ST_IDLE;
                end else begin
                    rsp_last_d = 1'b0;
                    word_cnt_d = word_cnt_q + 4'd1;
                    state_d    = ST_DATA;
                end
            end

            ST_WRITE: begin
                // Memory commits the write at the end of this cycle.
                mem_rd_wr_d = 1'b1;
                state_d     = ST_IDLE;
            end

            default: begin
                state_d     = ST_DRAIN;
                drain_cnt_d = DRAIN_INIT;
                mem_rd_wr_d = 1'b1;
            end
        endcase
    end

    // State, counter and output registers; reset restarts the drain window.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= ST_DRAIN;
            drain_cnt_q  <= DRAIN_INIT;
            word_cnt_q   <= 4'd0;
            last_idx_q   <= 4'd0;
            mem_enable_q <= 1'b0;
            mem_rd_wr_q  <= 1'b1;
            mem_size_q   <= SIZE_1W;
            mem_addr_q   <= 32'd0;
            mem_wdata_q  <= 32'd0;
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= 32'd0;
            rsp_index_q  <= 4'd0;
            rsp_last_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            drain_cnt_q  <= drain_cnt_d;
            word_cnt_q   <= word_cnt_d;
            last_idx_q   <= last_idx_d;
            mem_enable_q <= mem_enable_d;
            mem_rd_wr_q  <= mem_rd_wr_d;
            mem_size_q   <= mem_size_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
            rsp_index_q  <= rsp_index_d;
            rsp_last_q   <= rsp_last_d;
        end
    end

    assign req_ready_o       = (state_q == ST_IDLE);
    assign rsp_valid_o       = rsp_valid_q;
    assign rsp_data_o        = rsp_data_q;
    assign rsp_index_o       = rsp_index_q;
    assign rsp_last_o        = rsp_last_q;
    assign mem_enable_o      = mem_enable_q;
    assign mem_rd_wr_o       = mem_rd_wr_q;
    assign mem_access_size_o = mem_size_q;
    assign mem_addr_o        = mem_addr_q;
    assign mem_data_in_o     = mem_wdata_q;

endmodule

// File: tb/tb_mem_requester.sv
// Self-checking bench for mem_requester: a behavioural burst memory plus a
// cycle-level expectation model derived from the request/response timing.
module tb_mem_requester;

    localparam int DRAIN = 18;
    localparam int MEMW  = 1024;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        req_ready, rsp_valid, rsp_last, mem_enable, mem_rd_wr;
    logic [31:0] rsp_data, mem_addr, mem_data_in;
    logic [31:0] mem_data_out = 32'd0;
    logic [3:0]  rsp_index;
    logic [1:0]  mem_access_size;

    always #5 clk = ~clk;

    mem_requester #(.DRAIN_CYCLES(DRAIN)) dut (
        .clk_i(clk), .reset_i(reset),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_write_i(req_write),
        .req_size_i(req_size), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .rsp_valid_o(rsp_valid), .rsp_data_o(rsp_data), .rsp_index_o(rsp_index),
        .rsp_last_o(rsp_last), .mem_enable_o(mem_enable), .mem_rd_wr_o(mem_rd_wr),
        .mem_access_size_o(mem_access_size), .mem_addr_o(mem_addr),
        .mem_data_in_o(mem_data_in), .mem_data_out_i(mem_data_out)
    );

    function automatic int words_of(input logic [1:0] s);
        return (s == 2'd0) ? 1 : (2 << s);
    endfunction

    // Burst memory: enable edge arms a burst, words follow on successive edges.
    logic [31:0] mem_arr [MEMW];
    logic        mem_loaded = 1'b0;
    int          mm_ptr = 0;
    int          mm_left = 0;
    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int i = 0; i < MEMW; i++) mem_arr[i] <= 32'hA000_0000 + 32'(i);
            mem_loaded <= 1'b1;
        end else if (mem_enable && !mem_rd_wr) begin
            mem_arr[mem_addr[11:2]] <= mem_data_in;
            mem_data_out <= 32'h0BAD_F00D;
        end else if (mem_enable) begin
            mm_ptr <= int'(mem_addr[11:2]);
            mm_left <= words_of(mem_access_size);
            mem_data_out <= 32'h0BAD_F00D;
        end else if (mm_left > 0) begin
            mem_data_out <= mem_arr[mm_ptr];
            mm_ptr <= (mm_ptr + 1) % MEMW;
            mm_left <= mm_left - 1;
        end else begin
            mem_data_out <= 32'h0BAD_F00D;
        end
    end

    // Expectation model
    typedef struct {
        int          c;
        logic [31:0] d;
        logic [3:0]  i;
        logic        l;
    } rsp_t;

    rsp_t        rq[$];
    logic [31:0] exp_mem [MEMW];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          ready_at = 32'h3FFF_FFFF;
    int          en_at = -1;
    int          n_acc = 0;
    int          acc_cyc = 0;
    logic        exp_wr = 1'b0;
    logic [1:0]  exp_size = 2'd0;
    logic [31:0] exp_addr = 32'd0;
    logic [31:0] exp_wdata = 32'd0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s (cycle %0d): observed %h expected %h", tag, cyc, obs, exp);
        end
    endtask

    task automatic check_reset_values();
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_last", 32'(rsp_last), 32'd0);
        chk("rst_mem_enable", 32'(mem_enable), 32'd0);
        chk("rst_mem_rd_wr", 32'(mem_rd_wr), 32'd1);
        chk("rst_mem_size", 32'(mem_access_size), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_data_in", mem_data_in, 32'd0);
        chk("rst_rsp_data", rsp_data, 32'd0);
        chk("rst_rsp_index", 32'(rsp_index), 32'd0);
    endtask

    task automatic model_accept(input int a);
        logic [31:0] ba;
        int          idx;
        int          len;
        rsp_t        r;
        ba = {req_addr[31:2], 2'b00};
        idx = int'(ba[11:2]);
        en_at = a + 1;
        exp_addr = ba;
        exp_wr = req_write;
        exp_wdata = req_wdata;
        exp_size = req_size;
        acc_cyc = a;
        n_acc++;
        if (req_write) begin
            exp_mem[idx] = req_wdata;
            ready_at = a + 2;
        end else begin
            len = words_of(req_size);
            for (int k = 0; k < len; k++) begin
                r.c = a + 4 + k;
                r.d = exp_mem[(idx + k) % MEMW];
                r.i = 4'(k);
                r.l = (k == len - 1);
                rq.push_back(r);
            end
            ready_at = a + 3 + len;
        end
    endtask

    // One clock cycle: check outputs mid-cycle, apply the handshake, advance.
    task automatic tick();
        rsp_t r;
        @(negedge clk);
        chk("req_ready", 32'(req_ready), 32'(cyc >= ready_at));
        chk("mem_enable", 32'(mem_enable), 32'(cyc == en_at));
        if (cyc == en_at) begin
            chk("mem_rd_wr", 32'(mem_rd_wr), 32'(!exp_wr));
            chk("mem_addr", mem_addr, exp_addr);
            if (exp_wr) chk("mem_data_in", mem_data_in, exp_wdata);
            else        chk("mem_access_size", 32'(mem_access_size), 32'(exp_size));
        end
        if (rq.size() > 0 && rq[0].c == cyc) begin
            r = rq.pop_front();
            chk("rsp_valid", 32'(rsp_valid), 32'd1);
            chk("rsp_data", rsp_data, r.d);
            chk("rsp_index", 32'(rsp_index), 32'(r.i));
            chk("rsp_last", 32'(rsp_last), 32'(r.l));
        end else begin
            chk("rsp_valid_idle", 32'(rsp_valid), 32'd0);
        end
        if (req_valid && cyc >= ready_at) model_accept(cyc);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_req(input logic w, input logic [1:0] sz, input logic [31:0] a,
                          input logic [31:0] wd, input logic keep);
        int start;
        int budget;
        start = n_acc;
        budget = 0;
        req_write = w;
        req_size = sz;
        req_addr = a;
        req_wdata = wd;
        req_valid = 1'b1;
        while (n_acc == start && budget < 200) begin
            tick();
            budget++;
        end
        if (n_acc == start) begin
            errors++;
            $error("FAIL accept_timeout: observed no accept in 200 cycles, expected an accept");
        end
        if (!keep) req_valid = 1'b0;
        // Scramble the request pins; only the latched copy may be used.
        req_addr = $urandom;
        req_wdata = $urandom;
        req_size = 2'($urandom);
        req_write = 1'($urandom);
    endtask

    task automatic do_reset(input int hold);
        reset = 1'b1;
        tick();
        rq.delete();
        en_at = -1;
        ready_at = 32'h3FFF_FFFF;
        check_reset_values();
        idle(hold);
        reset = 1'b0;
        ready_at = cyc + DRAIN;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic k;
        for (int i = 0; i < MEMW; i++) exp_mem[i] = 32'hA000_0000 + 32'(i);
        reset = 1'b1;
        @(posedge clk);
        #1;
        cyc = 1;
        check_reset_values();
        idle(2);
        reset = 1'b0;
        ready_at = cyc + DRAIN;

        // Directed: single word, 4-word burst, write then read-back.
        do_req(1'b0, 2'd0, 32'h0000_0040, 32'd0, 1'b0);
        idle(6);
        do_req(1'b0, 2'd1, 32'h0000_0100, 32'd0, 1'b0);
        idle(8);
        do_req(1'b1, 2'd0, 32'h0000_0200, 32'hDEAD_BEEF, 1'b0);
        do_req(1'b0, 2'd0, 32'h0000_0203, 32'd0, 1'b0);
        idle(6);

        // 16-word burst with the next request held pending throughout.
        do_req(1'b0, 2'd3, 32'h0000_0000, 32'd0, 1'b1);
        do_req(1'b0, 2'd0, 32'h0000_0044, 32'd0, 1'b0);
        idle(6);

        // Reset in the third DATA cycle of a 16-word burst.
        do_req(1'b0, 2'd3, 32'h0000_0000, 32'd0, 1'b0);
        while (cyc < acc_cyc + 5) tick();
        do_reset(2);
        do_req(1'b0, 2'd1, 32'h0000_0100, 32'd0, 1'b0);
        do_req(1'b0, 2'd0, 32'h0000_0200, 32'd0, 1'b0);
        idle(6);

        // Back-to-back single-word reads with valid held high.
        for (int i = 0; i < 6; i++) begin
            do_req(1'b0, 2'd0, 32'h0000_0300 + 32'(4 * i), 32'd0, (i < 5));
        end
        idle(6);

        // Randomised mix of reads and writes.
        for (int i = 0; i < 60; i++) begin
            k = (i < 59) ? 1'($urandom_range(0, 1)) : 1'b0;
            do_req(($urandom_range(0, 2) == 0), 2'($urandom), $urandom, $urandom, k);
            if (!k) idle($urandom_range(0, 3));
        end
        idle(24);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
